// File: rtl/inst_loader_pkg.sv
// Shared definitions for the instruction loader: op classes, mem/cmp sub-ops,
// terminator word, error codes and loader states.
package inst_loader_pkg;

   typedef enum logic [1:0] {
      CLS_MEMCMP = 2'b00,
      CLS_ONEVAR = 2'b01,
      CLS_TWOVAR = 2'b10,
      CLS_BRANCH = 2'b11
   } op_class_e;

   localparam logic [2:0] SUB_GET = 3'd0;
   localparam logic [2:0] SUB_PUT = 3'd1;
   localparam logic [2:0] SUB_LW  = 3'd2;
   localparam logic [2:0] SUB_SW  = 3'd3;
   localparam logic [2:0] SUB_SEQ = 3'd4;
   localparam logic [2:0] SUB_SNE = 3'd5;
   localparam logic [2:0] SUB_SLT = 3'd6;

   // Written after the last instruction; no real instruction may encode to it.
   localparam logic [8:0] ACK_WORD = 9'h1FF;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'b00,
      ERR_ILLEGAL = 2'b01,
      ERR_ALIAS   = 2'b10
   } err_code_e;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_TERM = 3'd2,
      S_DONE = 3'd3,
      S_ERR  = 3'd4
   } loader_state_e;

   function automatic logic memcmp_subop_ok(input logic [2:0] sub);
      return sub inside {SUB_GET, SUB_PUT, SUB_LW, SUB_SW, SUB_SEQ, SUB_SNE, SUB_SLT};
   endfunction

endpackage

// File: rtl/inst_loader_if.sv
// Instruction-in handshake and instruction-memory write bus of the loader.
interface inst_loader_if #(
   parameter int AW = 8
);
   logic          InValid;
   logic          InReady;
   logic [1:0]    InClass;
   logic [2:0]    InSub;
   logic [1:0]    InRa;
   logic [1:0]    InRb;
   logic [1:0]    InRt;
   logic [5:0]    InImm;
   logic          MemWe;
   logic [AW-1:0] MemAddr;
   logic [8:0]    MemWdata;

   modport master (
      output InValid, InClass, InSub, InRa, InRb, InRt, InImm,
      input  InReady, MemWe, MemAddr, MemWdata
   );

   modport slave (
      input  InValid, InClass, InSub, InRa, InRb, InRt, InImm,
      output InReady, MemWe, MemAddr, MemWdata
   );
endinterface

// File: rtl/inst_loader_encode.sv
// Combinational instruction encoder: decoded fields to a 9-bit machine word,
// flagging reserved sub-ops and words that collide with the terminator.
module inst_encode
   import inst_loader_pkg::*;
(
   input  logic [1:0] cls_i,
   input  logic [2:0] sub_i,
   input  logic [1:0] ra_i,
   input  logic [1:0] rb_i,
   input  logic [1:0] rt_i,
   input  logic [5:0] imm_i,
   output logic [8:0] word_o,
   output logic       illegal_o,
   output logic       alias_o
);

   // Field packing per op class, then terminator-collision detection.
   always_comb begin
      word_o    = 9'h000;
      illegal_o = 1'b0;
      case (cls_i)
         CLS_MEMCMP: begin
            word_o    = {2'b00, sub_i, ra_i, rb_i};
            illegal_o = !memcmp_subop_ok(sub_i);
         end
         CLS_ONEVAR: begin
            if (sub_i[0]) begin
               word_o = {2'b01, 1'b1, ra_i, 4'b0000};
            end else begin
               word_o = {2'b01, 1'b0, imm_i};
            end
         end
         CLS_TWOVAR: word_o = {2'b10, sub_i, ra_i, rb_i};
         CLS_BRANCH: word_o = {2'b11, sub_i[0], ra_i, rb_i, rt_i};
         default:    word_o = 9'h000;
      endcase
      alias_o = !illegal_o && (word_o == ACK_WORD);
   end

endmodule

// File: rtl/inst_loader.sv
// Program loader: accepts decoded instructions, writes their encodings to
// instruction memory from address 0 and appends the terminator on Finish.
module inst_loader
   import inst_loader_pkg::*;
#(
   parameter int AW = 8
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         Start,
   input  logic         Finish,
   inst_loader_if.slave bus,
   output logic [AW:0]  Count,
   output logic         Busy,
   output logic         Done,
   output logic         Error,
   output logic [1:0]   ErrCode
);

   localparam logic [AW-1:0] PTR_MAX = {AW{1'b1}};
   localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};

   loader_state_e state_q, state_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          pend_q, pend_d;
   logic          err_q, err_d;
   logic [1:0]    errcode_q, errcode_d;
   logic          we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [8:0]    wdata_q, wdata_d;
   logic          ready_q, ready_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic [8:0]    enc_word_s;
   logic          enc_illegal_s;
   logic          enc_alias_s;
   logic          xfer_s;

   inst_encode u_enc (
      .cls_i     (bus.InClass),
      .sub_i     (bus.InSub),
      .ra_i      (bus.InRa),
      .rb_i      (bus.InRb),
      .rt_i      (bus.InRt),
      .imm_i     (bus.InImm),
      .word_o    (enc_word_s),
      .illegal_o (enc_illegal_s),
      .alias_o   (enc_alias_s)
   );

   assign xfer_s = bus.InValid & ready_q;

   // Next-state, pointer/count and write-register logic.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      count_d   = count_q;
      pend_d    = pend_q;
      err_d     = err_q;
      errcode_d = errcode_q;
      we_d      = 1'b0;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (Start) begin
               state_d   = S_LOAD;
               ptr_d     = '0;
               count_d   = '0;
               pend_d    = 1'b0;
               err_d     = 1'b0;
               errcode_d = ERR_NONE;
            end else begin
               state_d = state_q;
            end
         end
         S_LOAD: begin
            if (xfer_s && (enc_illegal_s || enc_alias_s)) begin
               state_d   = S_ERR;
               err_d     = 1'b1;
               errcode_d = enc_illegal_s ? ERR_ILLEGAL : ERR_ALIAS;
            end else if (xfer_s) begin
               we_d    = 1'b1;
               addr_d  = ptr_q;
               wdata_d = enc_word_s;
               ptr_d   = ptr_q + PTR_ONE;
               count_d = count_q + CNT_ONE;
               pend_d  = pend_q | Finish;
            end else if (pend_q || Finish) begin
               // Any earlier write is already on the bus, so the terminator can follow.
               state_d = S_TERM;
               pend_d  = 1'b1;
            end else begin
               state_d = S_LOAD;
            end
         end
         S_TERM: begin
            state_d = S_DONE;
            we_d    = 1'b1;
            addr_d  = ptr_q;
            wdata_d = ACK_WORD;
            count_d = count_q + CNT_ONE;
         end
         default: state_d = S_IDLE;
      endcase
      ready_d = (state_d == S_LOAD) && !pend_d && (ptr_d != PTR_MAX);
      busy_d  = (state_d == S_LOAD) || (state_d == S_TERM);
      done_d  = (state_d == S_DONE);
   end

   // State and output registers; Reset overrides every input.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= S_IDLE;
         ptr_q     <= '0;
         count_q   <= '0;
         pend_q    <= 1'b0;
         err_q     <= 1'b0;
         errcode_q <= ERR_NONE;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= 9'h000;
         ready_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         count_q   <= count_d;
         pend_q    <= pend_d;
         err_q     <= err_d;
         errcode_q <= errcode_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign bus.InReady  = ready_q;
   assign bus.MemWe    = we_q;
   assign bus.MemAddr  = addr_q;
   assign bus.MemWdata = wdata_q;
   assign Count        = count_q;
   assign Busy         = busy_q;
   assign Done         = done_q;
   assign Error        = err_q;
   assign ErrCode      = errcode_q;

endmodule

// File: tb/tb_inst_loader.sv
// Bench for inst_loader: drives an AW=8 and an AW=2 instance with the same
// directed vectors and checks both against a cycle model built from the rules.
module tb_inst_loader;

   logic Clk = 1'b0;
   logic Reset, Start, Finish;
   always #5 Clk = ~Clk;

   inst_loader_if #(.AW(8)) if8 ();
   inst_loader_if #(.AW(2)) if2 ();

   logic [8:0] cnt8;
   logic [2:0] cnt2;
   logic       busy8, done8, err8, busy2, done2, err2;
   logic [1:0] code8, code2;

   inst_loader #(.AW(8)) u_dut8 (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Finish(Finish), .bus(if8.slave),
      .Count(cnt8), .Busy(busy8), .Done(done8), .Error(err8), .ErrCode(code8)
   );
   inst_loader #(.AW(2)) u_dut2 (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Finish(Finish), .bus(if2.slave),
      .Count(cnt2), .Busy(busy2), .Done(done2), .Error(err2), .ErrCode(code2)
   );

   int n_chk = 0;
   int n_err = 0;

   localparam int MI = 0, ML = 1, MT = 2, MD = 3, ME = 4;
   int m_st[2], m_ptr[2], m_cnt[2], m_pend[2], m_err[2], m_code[2];
   int m_we[2], m_addr[2], m_wd[2];
   int depth[2] = '{256, 4};

   logic [8:0] obs8 [256];
   logic [8:0] obs2 [4];
   int nw8, nw2;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic mdl_enc(input int c, input int s, input int a, input int b, input int t,
                          input int im, output int w, output int ill);
      ill = 0;
      case (c)
         0: begin w = s * 16 + a * 4 + b; ill = (s == 7) ? 1 : 0; end
         1: w = (s % 2 == 1) ? 192 + a * 16 : 128 + im;
         2: w = 256 + s * 16 + a * 4 + b;
         default: w = 384 + (s % 2) * 64 + a * 16 + b * 4 + t;
      endcase
   endtask

   function automatic int mdl_ready(input int k);
      return (m_st[k] == ML && m_pend[k] == 0 && m_ptr[k] < depth[k] - 1) ? 1 : 0;
   endfunction

   task automatic mdl_step(input int k, input int rst, input int st, input int fin, input int v,
                           input int c, input int s, input int a, input int b, input int t,
                           input int im);
      int w, ill, rdy;
      rdy = mdl_ready(k);
      m_we[k] = 0;
      if (rst != 0) begin
         m_st[k] = MI; m_ptr[k] = 0; m_cnt[k] = 0; m_pend[k] = 0;
         m_err[k] = 0; m_code[k] = 0; m_addr[k] = 0; m_wd[k] = 0;
      end else if (m_st[k] == ML) begin
         if (v != 0 && rdy != 0) begin
            mdl_enc(c, s, a, b, t, im, w, ill);
            if (ill != 0) begin
               m_err[k] = 1; m_code[k] = 1; m_st[k] = ME;
            end else if (w == 511) begin
               m_err[k] = 1; m_code[k] = 2; m_st[k] = ME;
            end else begin
               m_we[k] = 1; m_addr[k] = m_ptr[k]; m_wd[k] = w;
               m_ptr[k]++; m_cnt[k]++;
               if (fin != 0) m_pend[k] = 1;
            end
         end else if (m_pend[k] != 0 || fin != 0) begin
            m_st[k] = MT;
         end
      end else if (m_st[k] == MT) begin
         m_we[k] = 1; m_addr[k] = m_ptr[k]; m_wd[k] = 511; m_cnt[k]++; m_st[k] = MD;
      end else if (st != 0) begin
         m_st[k] = ML; m_ptr[k] = 0; m_cnt[k] = 0; m_pend[k] = 0; m_err[k] = 0; m_code[k] = 0;
      end
   endtask

   task automatic cmp(input int k, input logic rdy, input logic we, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] cnt, input logic busy,
                      input logic done, input logic err, input logic [1:0] code);
      string p;
      p = (k == 0) ? "aw8" : "aw2";
      chk({p, " InReady"}, rdy, mdl_ready(k));
      chk({p, " MemWe"}, we, m_we[k]);
      chk({p, " MemAddr"}, addr, m_addr[k]);
      chk({p, " MemWdata"}, wd, m_wd[k]);
      chk({p, " Count"}, cnt, m_cnt[k]);
      chk({p, " Busy"}, busy, (m_st[k] == ML || m_st[k] == MT) ? 1 : 0);
      chk({p, " Done"}, done, (m_st[k] == MD) ? 1 : 0);
      chk({p, " Error"}, err, m_err[k]);
      chk({p, " ErrCode"}, code, m_code[k]);
   endtask

   task automatic drive_if(input int v, input int c, input int s, input int a, input int b,
                           input int t, input int im);
      if8.InValid = v[0]; if8.InClass = c[1:0]; if8.InSub = s[2:0];
      if8.InRa = a[1:0]; if8.InRb = b[1:0]; if8.InRt = t[1:0]; if8.InImm = im[5:0];
      if2.InValid = v[0]; if2.InClass = c[1:0]; if2.InSub = s[2:0];
      if2.InRa = a[1:0]; if2.InRb = b[1:0]; if2.InRt = t[1:0]; if2.InImm = im[5:0];
   endtask

   task automatic cyc(input int rst, input int st, input int fin, input int v, input int c,
                      input int s, input int a, input int b, input int t, input int im);
      Reset = rst[0]; Start = st[0]; Finish = fin[0];
      drive_if(v, c, s, a, b, t, im);
      mdl_step(0, rst, st, fin, v, c, s, a, b, t, im);
      mdl_step(1, rst, st, fin, v, c, s, a, b, t, im);
      @(posedge Clk);
      #1;
      cmp(0, if8.InReady, if8.MemWe, 32'(if8.MemAddr), 32'(if8.MemWdata), 32'(cnt8),
          busy8, done8, err8, code8);
      cmp(1, if2.InReady, if2.MemWe, 32'(if2.MemAddr), 32'(if2.MemWdata), 32'(cnt2),
          busy2, done2, err2, code2);
      if (if8.MemWe === 1'b1) begin obs8[if8.MemAddr] = if8.MemWdata; nw8++; end
      if (if2.MemWe === 1'b1) begin obs2[if2.MemAddr] = if2.MemWdata; nw2++; end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic clr_obs();
      for (int i = 0; i < 256; i++) obs8[i] = 9'h000;
      for (int i = 0; i < 4; i++) obs2[i] = 9'h000;
      nw8 = 0;
      nw2 = 0;
   endtask

   initial begin
      clr_obs();
      // Reset held together with Start: Start must not take effect.
      cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("reset MemWe", if8.MemWe, 1'b0);
      chk("reset Count", cnt8, 9'd0);
      idle(2);

      // Start; two-var sub 0 Ra=1 Rb=2; Finish (Start during Finish is ignored).
      clr_obs();
      cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 2, 0, 1, 2, 0, 0);
      cyc(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      idle(3);
      chk("basic addr0", obs8[0], 9'h106);
      chk("basic addr1", obs8[1], 9'h1FF);
      chk("basic Count", cnt8, 9'd2);
      chk("basic Done", done8, 1'b1);

      // One-var set and not; the not arrives together with Finish.
      clr_obs();
      cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 1, 0, 0, 0, 0, 42);
      cyc(0, 0, 1, 1, 1, 1, 2, 0, 0, 63);
      idle(4);
      chk("set word", obs8[0], 9'h0AA);
      chk("not word", obs8[1], 9'h0E0);
      chk("same-cycle term", obs8[2], 9'h1FF);
      chk("onevar Count", cnt8, 9'd3);

      // Reserved mem/cmp sub-op, then restart from ERR.
      clr_obs();
      cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 7, 1, 1, 0, 0);
      idle(2);
      chk("illegal Error", err8, 1'b1);
      chk("illegal ErrCode", code8, 2'b01);
      chk("illegal no write", nw8, 0);
      cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("restart Error", err8, 1'b0);
      cyc(0, 0, 0, 1, 0, 3, 1, 1, 0, 0);
      cyc(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      idle(3);
      chk("restart addr0", obs8[0], 9'h035);

      // Branch down with Ra=Rb=Rt=3 encodes to the terminator value.
      clr_obs();
      cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 3, 1, 3, 3, 3, 0);
      idle(2);
      chk("alias ErrCode", code8, 2'b10);
      chk("alias no write", nw8, 0);

      // InValid held for six cycles: the 4-word instance fills and stalls.
      clr_obs();
      cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 2, 1, 0, 1, 0, 0);
      cyc(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      idle(3);
      chk("full addr3", obs2[3], 9'h1FF);
      chk("full Count", cnt2, 3'd4);
      chk("full Error", err2, 1'b0);
      chk("full writes", nw2, 4);
      chk("wide Count", cnt8, 9'd7);

      // Transfer with Finish, then Reset while in TERM: no terminator.
      clr_obs();
      cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 1, 1, 2, 0, 1, 2, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("pre-abort Busy", busy8, 1'b1);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(3);
      chk("abort writes", nw8, 1);
      chk("abort addr0", obs8[0], 9'h106);
      chk("abort no term", obs8[1], 9'h000);
      chk("abort Count", cnt8, 9'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
